// File: rtl/mips_pipe_core_p_if.sv
// Control, program-load and status bus of the five-stage MIPS32 core.
// The bench/host drives the master side; the core sits on the slave side.
interface mips_pipe_core_p_if #(
   parameter int XLEN = 32,
   parameter int IAW  = 10,
   parameter int DAW  = 10
);
   logic            start;
   logic [IAW-1:0]  boot_pc;
   logic            prog_we;
   logic [IAW-1:0]  prog_addr;
   logic [31:0]     prog_data;
   logic [DAW-1:0]  dbg_addr;
   logic [XLEN-1:0] dbg_data;
   logic            busy;
   logic            halted;
   logic            illegal;
   logic [31:0]     retired;

   modport master (output start, boot_pc, prog_we, prog_addr, prog_data, dbg_addr,
                   input  dbg_data, busy, halted, illegal, retired);
   modport slave  (input  start, boot_pc, prog_we, prog_addr, prog_data, dbg_addr,
                   output dbg_data, busy, halted, illegal, retired);
endinterface

// File: rtl/mips_pipe_core_p.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) with interlocks,
// optional EX bypass, EX-resolved branches and a run/drain/halt controller.
module mips_pipe_core_p #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024,
   parameter int FORWARD    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mips_pipe_core_p_if.slave  bus
);
   localparam int   IAW = $clog2(IMEM_DEPTH);
   localparam int   DAW = $clog2(DMEM_DEPTH);
   localparam int   RAW = $clog2(NREG);
   localparam logic FWD = (FORWARD != 0);

   localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_AND   = 6'd2,
                          OP_OR   = 6'd3,  OP_SLT  = 6'd4,  OP_MUL   = 6'd5,
                          OP_LW   = 6'd8,  OP_SW   = 6'd9,  OP_ADDI  = 6'd10,
                          OP_SUBI = 6'd11, OP_SLTI = 6'd12, OP_BNEQZ = 6'd13,
                          OP_BEQZ = 6'd14, OP_HLT  = 6'd63;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

   typedef struct packed {
      logic           v;
      logic [31:0]    ir;
      logic [IAW-1:0] npc;
   } if_id_t;

   typedef struct packed {
      logic            v;
      logic [5:0]      op;
      logic [RAW-1:0]  rs, rt, dst;
      logic            we, lw, sw, rr, stop, ill;
      logic [XLEN-1:0] a, b, imm;
      logic [IAW-1:0]  npc;
   } id_ex_t;

   typedef struct packed {
      logic            v;
      logic [RAW-1:0]  dst;
      logic            we, lw, sw, stop, ill;
      logic [XLEN-1:0] alu, sd;
   } ex_mem_t;

   typedef struct packed {
      logic            v;
      logic [RAW-1:0]  dst;
      logic            we, stop, ill;
      logic [XLEN-1:0] val;
   } mem_wb_t;

   state_t          state, nstate;
   logic [IAW-1:0]  pc, pc_inc;
   if_id_t          if_id;
   id_ex_t          id_ex, id_dec;
   ex_mem_t         ex_mem, ex_nx;
   mem_wb_t         mem_wb, wb_nx;

   logic [31:0]     imem [IMEM_DEPTH];
   logic [XLEN-1:0] dmem [DMEM_DEPTH];
   logic [XLEN-1:0] rf   [NREG];

   logic [5:0]      id_op;
   logic [RAW-1:0]  id_rs, id_rt, id_rd;
   logic            id_rr, id_rm, id_lw, id_sw, id_br, id_ill, id_stop;
   logic            use_rs, use_rt, stall, halt_dec, fetch, start_acc;
   logic [XLEN-1:0] rd_a, rd_b, fa, fb, y, alu;
   logic            br_take;
   logic [IAW-1:0]  br_tgt;
   logic [DAW-1:0]  mem_addr;

   // ---------------- control FSM ----------------
   assign start_acc = bus.start && (state == S_IDLE || state == S_HALT);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE, S_HALT: if (bus.start) nstate = S_RUN;
         S_RUN:          if (halt_dec) nstate = S_DRAIN;
         S_DRAIN:        if (mem_wb.v && mem_wb.stop) nstate = S_HALT;
         default:        nstate = S_IDLE;
      endcase
   end

   assign bus.busy   = (state == S_RUN) || (state == S_DRAIN);
   assign bus.halted = (state == S_HALT);

   // ---------------- decode ----------------
   assign id_op   = if_id.ir[31:26];
   assign id_rs   = if_id.ir[21 +: RAW];
   assign id_rt   = if_id.ir[16 +: RAW];
   assign id_rd   = if_id.ir[11 +: RAW];
   assign id_rr   = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
   assign id_rm   = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
   assign id_lw   = (id_op == OP_LW);
   assign id_sw   = (id_op == OP_SW);
   assign id_br   = (id_op == OP_BEQZ) || (id_op == OP_BNEQZ);
   assign id_ill  = !(id_rr || id_rm || id_lw || id_sw || id_br || id_op == OP_HLT);
   assign id_stop = (id_op == OP_HLT) || id_ill;
   assign use_rs  = id_rr || id_rm || id_lw || id_sw || id_br;
   assign use_rt  = id_rr || id_sw;

   // Write-first: the WB write is seen by the ID read in the same cycle.
   assign rd_a = (mem_wb.we && mem_wb.dst == id_rs) ? mem_wb.val : rf[id_rs];
   assign rd_b = (mem_wb.we && mem_wb.dst == id_rt) ? mem_wb.val : rf[id_rt];

   always_comb begin
      id_dec      = '0;
      id_dec.v    = 1'b1;
      id_dec.op   = id_op;
      id_dec.rs   = id_rs;
      id_dec.rt   = id_rt;
      id_dec.dst  = id_rr ? id_rd : id_rt;
      id_dec.we   = (id_rr || id_rm || id_lw) && (id_dec.dst != '0);
      id_dec.lw   = id_lw;
      id_dec.sw   = id_sw;
      id_dec.rr   = id_rr;
      id_dec.stop = id_stop;
      id_dec.ill  = id_ill;
      id_dec.a    = rd_a;
      id_dec.b    = rd_b;
      id_dec.imm  = XLEN'($signed(if_id.ir[15:0]));
      id_dec.npc  = if_id.npc;
   end

   // With bypass only a load one ahead interlocks; without it any in-flight
   // writer not yet in WB does (WB itself is covered by write-first).
   function automatic logic dep(input logic we, input logic [RAW-1:0] dst);
      return we && ((use_rs && dst == id_rs) || (use_rt && dst == id_rt));
   endfunction

   assign stall = if_id.v &&
                  (FWD ? (id_ex.lw && dep(id_ex.we, id_ex.dst))
                       : (dep(id_ex.we, id_ex.dst) || dep(ex_mem.we, ex_mem.dst)));

   // ---------------- execute ----------------
   assign fa = (FWD && ex_mem.we && !ex_mem.lw && ex_mem.dst == id_ex.rs) ? ex_mem.alu :
               (FWD && mem_wb.we && mem_wb.dst == id_ex.rs)               ? mem_wb.val : id_ex.a;
   assign fb = (FWD && ex_mem.we && !ex_mem.lw && ex_mem.dst == id_ex.rt) ? ex_mem.alu :
               (FWD && mem_wb.we && mem_wb.dst == id_ex.rt)               ? mem_wb.val : id_ex.b;
   assign y  = id_ex.rr ? fb : id_ex.imm;

   always_comb begin
      alu = '0;
      case (id_ex.op)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: alu = fa + y;
         OP_SUB, OP_SUBI:               alu = fa - y;
         OP_AND:                        alu = fa & y;
         OP_OR:                         alu = fa | y;
         OP_SLT, OP_SLTI:               alu = XLEN'($signed(fa) < $signed(y));
         OP_MUL:                        alu = fa * y;
         default:                       alu = '0;
      endcase
   end

   assign br_take  = id_ex.v && ((id_ex.op == OP_BEQZ  && fa == '0) ||
                                 (id_ex.op == OP_BNEQZ && fa != '0));
   assign br_tgt   = id_ex.npc + id_ex.imm[IAW-1:0];
   // An HLT sitting behind a taken branch is wrong-path and must not drain.
   assign halt_dec = (state == S_RUN) && if_id.v && id_stop && !br_take;
   assign fetch    = (state == S_RUN) && !halt_dec;
   assign pc_inc   = pc + 1'b1;

   always_comb begin
      ex_nx      = '0;
      ex_nx.v    = id_ex.v;
      ex_nx.dst  = id_ex.dst;
      ex_nx.we   = id_ex.we;
      ex_nx.lw   = id_ex.lw;
      ex_nx.sw   = id_ex.sw;
      ex_nx.stop = id_ex.stop;
      ex_nx.ill  = id_ex.ill;
      ex_nx.alu  = alu;
      ex_nx.sd   = fb;
   end

   // ---------------- memory ----------------
   assign mem_addr = ex_mem.alu[DAW-1:0];

   always_comb begin
      wb_nx      = '0;
      wb_nx.v    = ex_mem.v;
      wb_nx.dst  = ex_mem.dst;
      wb_nx.we   = ex_mem.we;
      wb_nx.stop = ex_mem.stop;
      wb_nx.ill  = ex_mem.ill;
      wb_nx.val  = ex_mem.lw ? dmem[mem_addr] : ex_mem.alu;
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         if_id  <= '0;
         id_ex  <= '0;
         ex_mem <= '0;
         mem_wb <= '0;
      end else begin
         if (start_acc)            pc <= bus.boot_pc;
         else if (br_take)         pc <= br_tgt;
         else if (fetch && !stall) pc <= pc_inc;

         if (br_take || (!stall && !fetch)) if_id <= '0;
         else if (!stall)                   if_id <= '{v: 1'b1, ir: imem[pc], npc: pc_inc};

         if (br_take || stall || !if_id.v) id_ex <= '0;
         else                              id_ex <= id_dec;

         ex_mem <= id_ex.v  ? ex_nx : '0;
         mem_wb <= ex_mem.v ? wb_nx : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (mem_wb.we) begin
         rf[mem_wb.dst] <= mem_wb.val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.retired <= '0;
         bus.illegal <= 1'b0;
      end else if (start_acc) begin
         bus.retired <= '0;
         bus.illegal <= 1'b0;
      end else if (mem_wb.v) begin
         bus.retired <= bus.retired + 32'd1;
         if (mem_wb.ill) bus.illegal <= 1'b1;
      end
   end

   // Memories keep their contents across reset.
   always_ff @(posedge clk) begin
      if (bus.prog_we && !bus.busy) imem[bus.prog_addr] <= bus.prog_data;
      if (ex_mem.v && ex_mem.sw)    dmem[mem_addr]      <= ex_mem.sd;
   end

   assign bus.dbg_data = dmem[bus.dbg_addr];
endmodule

// File: tb/tb_mips_pipe_core_p.sv
// Directed bench: one bypassing core and one interlock-only core share all
// inputs; registers are observed by running a store-dump program.
module tb_mips_pipe_core_p;
   localparam logic [5:0] OP_ADD = 6'd0, OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10,
                          OP_BEQZ = 6'd14;
   localparam logic [31:0] HLT = {6'h3f, 26'd0};
   localparam logic [31:0] BAD = {6'b010000, 26'd0};
   localparam int DUMP = 200;

   logic        clk, rst_n, start, prog_we;
   logic [9:0]  boot_pc, prog_addr, dbg_addr;
   logic [31:0] prog_data;
   int          checks, errors, h0, h1;

   mips_pipe_core_p_if #(.XLEN(32), .IAW(10), .DAW(10)) bus0 ();
   mips_pipe_core_p_if #(.XLEN(32), .IAW(10), .DAW(10)) bus1 ();

   assign bus0.start = start;     assign bus1.start = start;
   assign bus0.boot_pc = boot_pc; assign bus1.boot_pc = boot_pc;
   assign bus0.prog_we = prog_we; assign bus1.prog_we = prog_we;
   assign bus0.prog_addr = prog_addr; assign bus1.prog_addr = prog_addr;
   assign bus0.prog_data = prog_data; assign bus1.prog_data = prog_data;
   assign bus0.dbg_addr = dbg_addr;   assign bus1.dbg_addr = dbg_addr;

   mips_pipe_core_p #(.FORWARD(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   mips_pipe_core_p #(.FORWARD(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(input int addr, input logic [31:0] w);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 10'(addr); prog_data = w;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Pulse start; report the edge index (E0 = start edge) at which each core halted.
   task automatic run(input int boot, output int e0, output int e1);
      @(negedge clk);
      start = 1'b1; boot_pc = 10'(boot);
      @(posedge clk); #1 start = 1'b0;
      e0 = -1; e1 = -1;
      for (int k = 1; k <= 200 && (e0 < 0 || e1 < 0); k++) begin
         @(posedge clk); #1;
         if (e0 < 0 && bus0.halted) e0 = k;
         if (e1 < 0 && bus1.halted) e1 = k;
      end
   endtask

   task automatic peek(input string nm, input int a, input int v);
      dbg_addr = 10'(a); #1;
      chk({nm, ".u0"}, 64'(bus0.dbg_data), 64'(v));
      chk({nm, ".u1"}, 64'(bus1.dbg_data), 64'(v));
   endtask

   typedef struct {
      string nm;
      int    boot, halt, ret;
      bit    ill, poke, dump;
      int    a1, v1, a2, v2;
   } run_t;
   run_t tv [5];

   initial begin
      checks = 0; errors = 0;
      start = 0; boot_pc = 0; prog_we = 0; prog_addr = 0; prog_data = 0; dbg_addr = 0;
      rst_n = 0;
      tv[0] = '{"setup",    64,  7, 3, 0, 0, 0,  5,  7, -1,  0};
      tv[1] = '{"t1_fwd",    0,  8, 4, 0, 1, 1, 35, 30, 33, 10};
      tv[2] = '{"t2_load",  16, 10, 5, 0, 0, 0,  6, 14,  5,  7};
      tv[3] = '{"t3_branch",32, 10, 4, 0, 0, 1, 33,  1, 36,  2};
      tv[4] = '{"t6_illeg", 48,  7, 3, 1, 0, 1, 32,  0, 33,  0};

      #1;
      chk("rst.busy.u0", bus0.busy, 0);       chk("rst.busy.u1", bus1.busy, 0);
      chk("rst.halted.u0", bus0.halted, 0);   chk("rst.halted.u1", bus1.halted, 0);
      chk("rst.illegal.u0", bus0.illegal, 0); chk("rst.illegal.u1", bus1.illegal, 0);
      chk("rst.retired.u0", bus0.retired, 0); chk("rst.retired.u1", bus1.retired, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      load(0,  ri(OP_ADDI, 1, 0, 10)); load(1, ri(OP_ADDI, 2, 0, 20));
      load(2,  rr(OP_ADD, 3, 1, 2));   load(3, HLT);
      load(16, ri(OP_ADDI, 1, 0, 5));  load(17, ri(OP_LW, 2, 1, 0));
      load(18, rr(OP_ADD, 3, 2, 2));   load(19, ri(OP_SW, 3, 1, 1)); load(20, HLT);
      load(32, ri(OP_ADDI, 1, 0, 1));  load(33, ri(OP_BEQZ, 0, 0, 2));
      load(34, ri(OP_ADDI, 1, 0, 99)); load(35, ri(OP_ADDI, 1, 0, 98));
      load(36, ri(OP_ADDI, 4, 1, 1));  load(37, HLT);
      load(48, ri(OP_ADDI, 0, 0, 5));  load(49, rr(OP_ADD, 1, 0, 0)); load(50, BAD);
      load(64, ri(OP_ADDI, 5, 0, 7));  load(65, ri(OP_SW, 5, 0, 5));  load(66, HLT);
      for (int k = 0; k < 5; k++) load(DUMP + k, ri(OP_SW, k, 0, 32 + k));
      load(DUMP + 5, HLT);

      for (int i = 0; i < 5; i++) begin
         if (tv[i].poke) begin
            // A program write while busy must be dropped (it targets the ADD).
            fork
               run(tv[i].boot, h0, h1);
               begin
                  repeat (3) @(negedge clk);
                  prog_we = 1'b1; prog_addr = 10'd2; prog_data = ri(OP_ADDI, 3, 0, 77);
                  @(negedge clk);
                  prog_we = 1'b0;
               end
            join
         end else begin
            run(tv[i].boot, h0, h1);
         end
         chk({tv[i].nm, ".halt_edge.u0"}, 64'(h0), 64'(tv[i].halt));
         chk({tv[i].nm, ".halted.u1"}, 64'(h1 > 0), 1);
         if (i == 1) chk("t4.nofwd_later", 64'(h1 > h0), 1);
         chk({tv[i].nm, ".retired.u0"}, bus0.retired, 64'(tv[i].ret));
         chk({tv[i].nm, ".retired.u1"}, bus1.retired, 64'(tv[i].ret));
         chk({tv[i].nm, ".illegal.u0"}, bus0.illegal, 64'(tv[i].ill));
         chk({tv[i].nm, ".illegal.u1"}, bus1.illegal, 64'(tv[i].ill));
         if (tv[i].dump) run(DUMP, h0, h1);
         if (tv[i].a1 >= 0) peek({tv[i].nm, ".m1"}, tv[i].a1, tv[i].v1);
         if (tv[i].a2 >= 0) peek({tv[i].nm, ".m2"}, tv[i].a2, tv[i].v2);
      end

      // Restart from HALTED: state persists, counters restart.
      run(0, h0, h1);
      chk("t4.restart.halted.u1", bus1.halted, 1);
      chk("t4.restart.retired.u1", bus1.retired, 4);
      chk("t4.restart.retired.u0", bus0.retired, 4);
      run(DUMP, h0, h1);
      peek("t4.restart.r3", 35, 30);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      start = 1'b1; boot_pc = 10'd0;
      @(posedge clk); #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("t5.pre.busy.u0", bus0.busy, 1);
      chk("t5.pre.retired.u0", bus0.retired, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5.busy.u0", bus0.busy, 0);       chk("t5.busy.u1", bus1.busy, 0);
      chk("t5.halted.u0", bus0.halted, 0);   chk("t5.halted.u1", bus1.halted, 0);
      chk("t5.retired.u0", bus0.retired, 0); chk("t5.retired.u1", bus1.retired, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(DUMP, h0, h1);
      chk("t5.dump_halt.u0", 64'(h0), 10);
      peek("t5.r3_cleared", 35, 0);
      peek("t5.dmem_kept", 6, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_pipe_core_p.md
Name: mips_pipe_core_p

Overview:
- Parametrised, single-clock successor to the team's two-phase MIPS32 pipeline.
- Five-stage in-order core: IF, ID, EX, MEM, WB.
- Same opcode set and encodings, with configurable data width, register count and memory depths.
- Adds interlocking, optional operand forwarding, branch flush, a run/halt controller with restart, program load, and retire/illegal status for the verification bench.

Parameters:
XLEN, 32, datapath/register width (16..64); immediates sign-extend from 16 to XLEN
NREG, 32, register count (power of 2, <=32); register index = low log2(NREG) bits of each 5-bit field
IMEM_DEPTH, 1024, instruction words (power of 2)
DMEM_DEPTH, 1024, data words of XLEN (power of 2)
FORWARD, 1, 1 = EX/MEM and MEM/WB bypass to EX; 0 = stall in ID until producer writes back

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted in IDLE or HALTED
boot_pc  in  log2(IMEM_DEPTH)  fetch address loaded on start
prog_we  in  1  instruction-memory write; ignored while busy
prog_addr  in  log2(IMEM_DEPTH)  imem write address
prog_data  in  32  imem write data
dbg_addr  in  log2(DMEM_DEPTH)  data-memory debug read address
dbg_data  out  XLEN  combinational Mem[dbg_addr]
busy  out  1  high in RUN and DRAIN
halted  out  1  high in HALTED
illegal  out  1  set when an invalid opcode retires; cleared by start
retired  out  32  count of non-bubble instructions written back, HLT included; wraps at 2^32

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, PC=0; all pipeline registers hold bubbles.
  - Register file = 0; busy=0, halted=0, illegal=0, retired=0.
  - Imem/dmem contents are not reset.
- FSM:
  - IDLE --start--> RUN: PC<=boot_pc at the start edge; illegal<=0, retired<=0.
  - RUN: when HLT or an invalid opcode is decoded in ID, IF stops fetching and injects bubbles; FSM goes to DRAIN.
  - DRAIN: when that instruction is in WB --> HALTED.
  - HALTED --start--> RUN. Registers and dmem persist across restart.
  - start while busy is ignored.
- Timing: with I0 fetched in the cycle after the start edge E0, instruction Ik writes back at edge E5+k when there are no stalls or flushes.
  - Consequence: halted rises at edge E(5+index of HLT).
- Invalid opcode: handled as HLT and sets illegal at WB.
- Register file:
  - r0 always reads 0; writes to r0 are dropped.
  - Write-first: a WB write is visible to the same-cycle ID read.
- ALU:
  - ADD/SUB/ADDI/SUBI wrap modulo 2^XLEN.
  - MUL yields the low XLEN bits.
  - SLT/SLTI are signed compares, result 0 or 1.
  - AND/OR are bitwise.
- Destination register: rd for RR ops; rt for RM ops and LW.
- Memory access: LW/SW address = (A+imm) mod DMEM_DEPTH. SW writes at the MEM-stage edge.
- Hazards, FORWARD=1:
  - Priority: EX/MEM result over MEM/WB result over register file, for both EX operands and SW store data.
  - Load-use (LW in EX, dependent instruction in ID): one stall cycle; PC and IF/ID hold, a bubble goes into EX.
- Hazards, FORWARD=0: ID stalls while any older in-flight instruction writes a source register of the ID instruction.
- Branches (BEQZ taken if A==0; BNEQZ taken if A!=0):
  - Resolved in EX; target = NPC + imm, taken modulo IMEM_DEPTH.
  - Taken: IF/ID and ID/EX are flushed to bubbles (2-cycle penalty); PC<=target at the same edge.
  - Not taken: no penalty.
  - A stall and a taken branch on the same edge: the flush wins.
- Bubbles never write the register file or dmem and never count in retired.
- prog_we while busy is dropped; while idle/halted it writes at the clock edge.

Test Plan:
1. Program ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT at boot_pc=0, FORWARD=1 -> r3=30, halted at E8, retired=4, illegal=0.
2. Dmem[5]=7; ADDI r1,r0,5; LW r2,0(r1); ADD r3,r2,r2; SW r3,1(r1); HLT -> Dmem[6]=14 via dbg read, halted at E10 (one load-use stall).
3. ADDI r1,r0,1; BEQZ r0,+2; ADDI r1,r0,99; ADDI r1,r0,98; ADDI r4,r1,1; HLT -> r1=1, r4=2, retired=4, skipped instructions have no effect.
4. FORWARD=0, program of test 1 -> r3=30, halted strictly later than E8; then pulse start again -> r3 still 30, retired=4.
5. Reset asserted mid-RUN -> busy/halted/retired immediately 0, r3 reads 0 after restart; dmem retains prior SW data.
6. ADDI r0,r0,5; ADD r1,r0,r0; opcode 6'b010000 -> r0=0, r1=0, illegal=1, halted=1, retired=3.
